// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard and pipeline-control unit for the 5-stage 16-bit MIPS core. Keeps a
// small scoreboard of what is in flight in EX, MEM and WB, and from it plus the
// current ID instruction produces:
//   - load-use detection (one-cycle stall of PC/IF-ID plus a bubble in ID/EX)
//   - EX operand forwarding selects and the WB->ID register-file bypass
//   - flushes of the younger pipeline registers on a taken branch
//   - a global freeze while the memory side is not ready
// Priority when several events coincide: mem_stall > branch_taken > load_use.
// Three saturating counters record load-use stall cycles, taken branches and
// memory-stall cycles.
//
// Parameters
//   REG_W        register-address width
//   BRANCH_STAGE stage that resolves branches (1=ID, 2=EX, 3=MEM); this many
//                younger pipeline registers are flushed on a taken branch
//   ZERO_REG     1: register 0 is hardwired zero and never creates a dependency
//   CNT_W        performance-counter width
//
// Ports
//   i_clk, i_rst_n             clock, synchronous active-low reset
//   i_mem_stall                memory/cache not ready, freezes the pipeline
//   i_branch_taken             taken branch resolved in BRANCH_STAGE
//   i_id_*                     ID-stage instruction: valid, sources, source-use
//                              flags, reg_write, mem_read, destination
//   o_stall_if                 hold PC and IF/ID
//   o_bubble_ex                load a NOP into ID/EX
//   o_flush_if_id/id_ex/ex_mem clear the register on the next edge
//   o_fwd_a, o_fwd_b           EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   o_id_byp_a, o_id_byp_b     WB->ID bypass for rs / rt
//   o_stall_cnt, o_flush_cnt,
//   o_miss_cnt                 saturating event counters
// -----------------------------------------------------------------------------

// Saturating up-counter: sticks at all-ones instead of wrapping.
module phc_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
endmodule

module pipe_hazard_ctrl #(
    parameter int REG_W        = 3,
    parameter int BRANCH_STAGE = 3,
    parameter int ZERO_REG     = 1,
    parameter int CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_mem_stall,
    input  logic             i_branch_taken,
    input  logic             i_id_valid,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_id_use_rs,
    input  logic             i_id_use_rt,
    input  logic             i_id_reg_write,
    input  logic             i_id_mem_read,
    input  logic [REG_W-1:0] i_id_dst,
    output logic             o_stall_if,
    output logic             o_bubble_ex,
    output logic             o_flush_if_id,
    output logic             o_flush_id_ex,
    output logic             o_flush_ex_mem,
    output logic [1:0]       o_fwd_a,
    output logic [1:0]       o_fwd_b,
    output logic             o_id_byp_a,
    output logic             o_id_byp_b,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt,
    output logic [CNT_W-1:0] o_miss_cnt
);
    // Which younger registers a taken branch clears, by resolving stage.
    localparam bit L_FLUSH_ID_EX  = (BRANCH_STAGE >= 2);
    localparam bit L_FLUSH_EX_MEM = (BRANCH_STAGE == 3);
    localparam int L_NCNT         = 3;

    // EX keeps the full source information for forwarding; MEM/WB only need
    // enough to act as forwarding sources.
    typedef struct packed {
        logic             reg_write;
        logic             mem_read;
        logic [REG_W-1:0] dst;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic             use_rs;
        logic             use_rt;
    } ex_ent_t;

    typedef struct packed {
        logic             reg_write;
        logic [REG_W-1:0] dst;
    } wb_ent_t;

    // Valid bits of the in-flight stages as a shift register: [0]=EX, [1]=MEM, [2]=WB.
    logic [2:0] r_vld_pipe;
    ex_ent_t    r_ex;
    wb_ent_t    r_mem;
    wb_ent_t    r_wb;

    function automatic logic f_match(
        input logic             vld,
        input logic             rw,
        input logic [REG_W-1:0] dst,
        input logic [REG_W-1:0] r
    );
        return vld && rw && (dst == r) && !((ZERO_REG != 0) && (r == '0));
    endfunction

    // ---------------------------------------------------------------- hazards
    logic w_ex_hit_rs;
    logic w_ex_hit_rt;
    logic w_load_use;
    logic w_ev_miss;
    logic w_ev_br;
    logic w_ev_lu;

    assign w_ex_hit_rs = i_id_use_rs && f_match(r_vld_pipe[0], r_ex.reg_write, r_ex.dst, i_id_rs);
    assign w_ex_hit_rt = i_id_use_rt && f_match(r_vld_pipe[0], r_ex.reg_write, r_ex.dst, i_id_rt);
    assign w_load_use  = i_id_valid && r_ex.mem_read && (w_ex_hit_rs || w_ex_hit_rt);

    // Exactly one event class is active per cycle after prioritisation.
    assign w_ev_miss = i_mem_stall;
    assign w_ev_br   = !i_mem_stall && i_branch_taken;
    assign w_ev_lu   = !i_mem_stall && !i_branch_taken && w_load_use;

    // ------------------------------------------------------------- forwarding
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;
    logic       w_byp_a;
    logic       w_byp_b;

    // EX/MEM result is newer than MEM/WB, so it is checked first.
    assign w_fwd_a = (r_ex.use_rs && f_match(r_vld_pipe[1], r_mem.reg_write, r_mem.dst, r_ex.rs)) ? 2'b10 :
                     f_match(r_vld_pipe[2], r_wb.reg_write, r_wb.dst, r_ex.rs)                    ? 2'b01 :
                                                                                                    2'b00;
    assign w_fwd_b = (r_ex.use_rt && f_match(r_vld_pipe[1], r_mem.reg_write, r_mem.dst, r_ex.rt)) ? 2'b10 :
                     f_match(r_vld_pipe[2], r_wb.reg_write, r_wb.dst, r_ex.rt)                    ? 2'b01 :
                                                                                                    2'b00;

    // Register file is read in ID while WB writes it in the same cycle.
    assign w_byp_a = i_id_use_rs && f_match(r_vld_pipe[2], r_wb.reg_write, r_wb.dst, i_id_rs);
    assign w_byp_b = i_id_use_rt && f_match(r_vld_pipe[2], r_wb.reg_write, r_wb.dst, i_id_rt);

    // ---------------------------------------------------------------- outputs
    // While in reset all pipeline registers are held cleared and nothing
    // forwards, so the first cycle after release sees an empty pipeline.
    always_comb begin
        o_stall_if     = 1'b0;
        o_bubble_ex    = 1'b0;
        o_flush_if_id  = 1'b0;
        o_flush_id_ex  = 1'b0;
        o_flush_ex_mem = 1'b0;
        o_fwd_a        = 2'b00;
        o_fwd_b        = 2'b00;
        o_id_byp_a     = 1'b0;
        o_id_byp_b     = 1'b0;
        if (!i_rst_n) begin
            o_flush_if_id  = 1'b1;
            o_flush_id_ex  = 1'b1;
            o_flush_ex_mem = 1'b1;
        end else begin
            o_stall_if     = w_ev_miss || w_ev_lu;
            o_bubble_ex    = w_ev_lu;
            o_flush_if_id  = w_ev_br;
            o_flush_id_ex  = w_ev_br && L_FLUSH_ID_EX;
            o_flush_ex_mem = w_ev_br && L_FLUSH_EX_MEM;
            o_fwd_a        = w_fwd_a;
            o_fwd_b        = w_fwd_b;
            o_id_byp_a     = w_byp_a;
            o_id_byp_b     = w_byp_b;
        end
    end

    // ------------------------------------------------------------- scoreboard
    // mem_stall freezes everything. Otherwise the pipe advances; a bubble or a
    // flush of ID/EX loads an all-zero (NOP) EX entry, and a flush of EX/MEM
    // drops the instruction that would have moved into MEM.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_vld_pipe <= '0;
            r_ex       <= '0;
            r_mem      <= '0;
            r_wb       <= '0;
        end else if (!i_mem_stall) begin
            r_wb          <= r_mem;
            r_vld_pipe[2] <= r_vld_pipe[1];
            r_mem         <= '{reg_write: r_ex.reg_write, dst: r_ex.dst};
            r_vld_pipe[1] <= r_vld_pipe[0] && !(w_ev_br && L_FLUSH_EX_MEM);
            if (w_ev_lu || (w_ev_br && L_FLUSH_ID_EX)) begin
                r_ex          <= '0;
                r_vld_pipe[0] <= 1'b0;
            end else begin
                r_ex <= '{reg_write: i_id_reg_write,
                          mem_read:  i_id_mem_read,
                          dst:       i_id_dst,
                          rs:        i_id_rs,
                          rt:        i_id_rt,
                          use_rs:    i_id_use_rs,
                          use_rt:    i_id_use_rt};
                r_vld_pipe[0] <= i_id_valid;
            end
        end
    end

    // --------------------------------------------------------------- counters
    // Index 0: load-use stall cycles, 1: taken branches, 2: mem_stall cycles.
    logic [L_NCNT-1:0]            w_cnt_inc;
    logic [L_NCNT-1:0][CNT_W-1:0] w_cnt;

    assign w_cnt_inc = {w_ev_miss, w_ev_br, w_ev_lu};

    for (genvar g = 0; g < L_NCNT; g++) begin : g_cnt
        phc_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_inc   (w_cnt_inc[g]),
            .o_cnt   (w_cnt[g])
        );
    end

    assign o_stall_cnt = w_cnt[0];
    assign o_flush_cnt = w_cnt[1];
    assign o_miss_cnt  = w_cnt[2];
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for pipe_hazard_ctrl. u_dut uses default parameters; u_sat uses a
// 4-bit counter and branches resolved in EX, and is compared only where its
// outputs do not depend on its (diverging) scoreboard history.
// Each cycle's expected control vector is queued as the stimulus is applied
// and popped when the outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, ms, bt, v, urs, urt, rw, mr;
    logic [2:0] rs, rt, dst;

    logic        stall_if, bubble_ex, f_ifid, f_idex, f_exmem, byp_a, byp_b;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt, flush_cnt, miss_cnt;

    logic       s_stall_if, s_bubble_ex, s_ifid, s_idex, s_exmem, s_byp_a, s_byp_b;
    logic [1:0] s_fwd_a, s_fwd_b;
    logic [3:0] s_stall_cnt, s_flush_cnt, s_miss_cnt;

    pipe_hazard_ctrl u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_mem_stall(ms), .i_branch_taken(bt),
        .i_id_valid(v), .i_id_rs(rs), .i_id_rt(rt), .i_id_use_rs(urs), .i_id_use_rt(urt),
        .i_id_reg_write(rw), .i_id_mem_read(mr), .i_id_dst(dst),
        .o_stall_if(stall_if), .o_bubble_ex(bubble_ex), .o_flush_if_id(f_ifid),
        .o_flush_id_ex(f_idex), .o_flush_ex_mem(f_exmem), .o_fwd_a(fwd_a), .o_fwd_b(fwd_b),
        .o_id_byp_a(byp_a), .o_id_byp_b(byp_b),
        .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt), .o_miss_cnt(miss_cnt)
    );

    pipe_hazard_ctrl #(.BRANCH_STAGE(2), .CNT_W(4)) u_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_mem_stall(ms), .i_branch_taken(bt),
        .i_id_valid(v), .i_id_rs(rs), .i_id_rt(rt), .i_id_use_rs(urs), .i_id_use_rt(urt),
        .i_id_reg_write(rw), .i_id_mem_read(mr), .i_id_dst(dst),
        .o_stall_if(s_stall_if), .o_bubble_ex(s_bubble_ex), .o_flush_if_id(s_ifid),
        .o_flush_id_ex(s_idex), .o_flush_ex_mem(s_exmem), .o_fwd_a(s_fwd_a), .o_fwd_b(s_fwd_b),
        .o_id_byp_a(s_byp_a), .o_id_byp_b(s_byp_b),
        .o_stall_cnt(s_stall_cnt), .o_flush_cnt(s_flush_cnt), .o_miss_cnt(s_miss_cnt)
    );

    typedef struct packed {
        logic       rst_n, ms, bt, v;
        logic [2:0] rs, rt;
        logic       urs, urt, rw, mr;
        logic [2:0] dst;
    } stim_t;

    // {stall_if, bubble_ex, flush_if_id, flush_id_ex, flush_ex_mem, fwd_a, fwd_b, byp_a, byp_b}
    typedef logic [10:0] exp_t;

    wire exp_t w_obs = {stall_if, bubble_ex, f_ifid, f_idex, f_exmem, fwd_a, fwd_b, byp_a, byp_b};

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    function automatic stim_t I(input logic iv, input logic [2:0] irs, irt,
                                input logic iurs, iurt, irw, imr, input logic [2:0] idst);
        stim_t s;
        s = '{rst_n: 1'b1, ms: 1'b0, bt: 1'b0, v: iv, rs: irs, rt: irt,
              urs: iurs, urt: iurt, rw: irw, mr: imr, dst: idst};
        return s;
    endfunction

    function automatic exp_t E(input logic st, bu, input logic [2:0] fl,
                               input logic [1:0] fa, fb, input logic ba, bb);
        return {st, bu, fl, fa, fb, ba, bb};
    endfunction

    localparam exp_t RST = 11'b00_111_00_00_00;

    // Apply one cycle of stimulus and queue what the outputs must be for it.
    task automatic issue(input stim_t s, input exp_t e);
        rst_n = s.rst_n; ms = s.ms; bt = s.bt; v = s.v;
        rs = s.rs; rt = s.rt; urs = s.urs; urt = s.urt;
        rw = s.rw; mr = s.mr; dst = s.dst;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        stim_t s[3];
        exp_t  x[3];
        exp_t  e;
        s[0] = I(1, 1, 2, 1, 1, 1, 1, 3); s[0].rst_n = 1'b0; s[0].ms = 1'b1;
        s[1] = I(1, 1, 2, 1, 1, 1, 1, 3); s[1].rst_n = 1'b0; s[1].bt = 1'b1;
        s[2] = I(0, 0, 0, 0, 0, 0, 0, 0);
        x = '{RST, RST, 11'd0};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            issue(s[i], x[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_chk++;
            if (w_obs !== e) begin n_err++; $display("FAIL reset[%0d]: got %b want %b", i, w_obs, e); end
        end
        n_chk++;
        if ({stall_cnt, flush_cnt, miss_cnt} !== 48'd0) begin
            n_err++; $display("FAIL reset counters: got %0d/%0d/%0d want 0/0/0", stall_cnt, flush_cnt, miss_cnt);
        end
        n_chk++;
        if ({s_stall_cnt, s_flush_cnt, s_miss_cnt} !== 12'd0) begin
            n_err++; $display("FAIL reset sat counters: got %0d/%0d/%0d want 0/0/0", s_stall_cnt, s_flush_cnt, s_miss_cnt);
        end
    endtask

    task automatic test_forward();
        stim_t s[9];
        exp_t  x[9];
        exp_t  e;
        s = '{I(1, 5, 6, 1, 1, 1, 0, 1), I(1, 1, 3, 1, 1, 1, 0, 2), I(1, 1, 7, 1, 1, 1, 0, 4),
              I(0, 0, 0, 0, 0, 0, 0, 0), I(1, 2, 4, 1, 1, 0, 0, 0), I(0, 0, 0, 0, 0, 0, 0, 0),
              I(0, 0, 0, 0, 0, 0, 0, 0), I(0, 0, 0, 0, 0, 0, 0, 0), I(0, 0, 0, 0, 0, 0, 0, 0)};
        x = '{11'd0, 11'd0, E(0, 0, 3'b000, 2'b10, 2'b00, 0, 0), E(0, 0, 3'b000, 2'b01, 2'b00, 0, 0),
              E(0, 0, 3'b000, 2'b00, 2'b00, 1, 0), E(0, 0, 3'b000, 2'b00, 2'b01, 0, 0),
              11'd0, 11'd0, 11'd0};
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            issue(s[i], x[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_chk++;
            if (w_obs !== e) begin n_err++; $display("FAIL forward[%0d]: got %b want %b", i, w_obs, e); end
        end
        n_chk++;
        if ({stall_cnt, flush_cnt, miss_cnt} !== 48'd0) begin
            n_err++; $display("FAIL forward counters: got %0d/%0d/%0d want 0/0/0", stall_cnt, flush_cnt, miss_cnt);
        end
    endtask

    task automatic test_load_use();
        stim_t s[14];
        exp_t  x[14];
        exp_t  e;
        s = '{I(1, 3, 2, 1, 0, 1, 1, 2), I(1, 2, 2, 1, 1, 1, 0, 4), I(1, 2, 2, 1, 1, 1, 0, 4),
              I(0, 0, 0, 0, 0, 0, 0, 0), I(0, 0, 0, 0, 0, 0, 0, 0), I(0, 0, 0, 0, 0, 0, 0, 0),
              I(1, 1, 5, 1, 0, 1, 1, 5), I(1, 5, 5, 0, 0, 0, 0, 0), I(1, 2, 6, 1, 0, 1, 1, 6),
              I(1, 0, 6, 0, 1, 1, 0, 7), I(1, 0, 6, 0, 1, 1, 0, 7), I(0, 0, 0, 0, 0, 0, 0, 0),
              I(0, 0, 0, 0, 0, 0, 0, 0), I(0, 0, 0, 0, 0, 0, 0, 0)};
        x = '{11'd0, E(1, 1, 3'b000, 2'b00, 2'b00, 0, 0), 11'd0,
              E(0, 0, 3'b000, 2'b01, 2'b01, 0, 0), 11'd0, 11'd0,
              11'd0, 11'd0, 11'd0,
              E(1, 1, 3'b000, 2'b00, 2'b00, 0, 0), 11'd0, E(0, 0, 3'b000, 2'b00, 2'b01, 0, 0),
              11'd0, 11'd0};
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            issue(s[i], x[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_chk++;
            if (w_obs !== e) begin n_err++; $display("FAIL load_use[%0d]: got %b want %b", i, w_obs, e); end
            if (i == 2) begin
                n_chk++;
                if (stall_cnt !== 16'd1) begin n_err++; $display("FAIL load_use stall_cnt: got %0d want 1", stall_cnt); end
            end
        end
        n_chk++;
        if (stall_cnt !== 16'd2) begin n_err++; $display("FAIL load_use stall_cnt end: got %0d want 2", stall_cnt); end
    endtask

    task automatic test_zero_reg();
        stim_t s[7];
        exp_t  e;
        s = '{I(1, 1, 0, 1, 0, 1, 1, 0), I(1, 0, 0, 1, 1, 1, 0, 3), I(1, 0, 0, 1, 1, 1, 0, 4),
              I(1, 0, 0, 1, 1, 0, 0, 0), I(0, 0, 0, 0, 0, 0, 0, 0), I(0, 0, 0, 0, 0, 0, 0, 0),
              I(0, 0, 0, 0, 0, 0, 0, 0)};
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            issue(s[i], 11'd0);
            @(negedge clk);
            e = exp_q.pop_front();
            n_chk++;
            if (w_obs !== e) begin n_err++; $display("FAIL zero_reg[%0d]: got %b want %b", i, w_obs, e); end
        end
        n_chk++;
        if (stall_cnt !== 16'd2) begin n_err++; $display("FAIL zero_reg stall_cnt: got %0d want 2", stall_cnt); end
    endtask

    task automatic test_branch();
        stim_t s[6];
        exp_t  x[6];
        exp_t  e;
        s = '{I(1, 3, 2, 1, 0, 1, 1, 2), I(1, 2, 2, 1, 1, 1, 0, 4), I(1, 2, 2, 1, 1, 1, 0, 5),
              I(0, 0, 0, 0, 0, 0, 0, 0), I(0, 0, 0, 0, 0, 0, 0, 0), I(0, 0, 0, 0, 0, 0, 0, 0)};
        s[1].bt = 1'b1;
        x = '{11'd0, E(0, 0, 3'b111, 2'b00, 2'b00, 0, 0), 11'd0, 11'd0, 11'd0, 11'd0};
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            issue(s[i], x[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_chk++;
            if (w_obs !== e) begin n_err++; $display("FAIL branch[%0d]: got %b want %b", i, w_obs, e); end
            if (i == 1) begin
                n_chk++;
                if ({s_stall_if, s_bubble_ex, s_ifid, s_idex, s_exmem} !== 5'b00110) begin
                    n_err++; $display("FAIL branch stage2 flushes: got %b want 00110",
                                      {s_stall_if, s_bubble_ex, s_ifid, s_idex, s_exmem});
                end
            end
        end
        n_chk++;
        if ({stall_cnt, flush_cnt} !== {16'd2, 16'd1}) begin
            n_err++; $display("FAIL branch counters: got stall %0d flush %0d want 2 1", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_mem_stall();
        stim_t s[11];
        exp_t  x[11];
        exp_t  e;
        s[0] = I(1, 3, 2, 1, 0, 1, 1, 2);
        x[0] = 11'd0;
        for (int i = 1; i < 8; i++) s[i] = I(1, 2, 2, 1, 1, 1, 0, 4);
        for (int i = 1; i < 6; i++) begin
            s[i].ms = 1'b1; s[i].bt = 1'b1;
            x[i] = E(1, 0, 3'b000, 2'b00, 2'b00, 0, 0);
        end
        x[6] = E(1, 1, 3'b000, 2'b00, 2'b00, 0, 0);
        x[7] = 11'd0;
        for (int i = 8; i < 11; i++) s[i] = I(0, 0, 0, 0, 0, 0, 0, 0);
        x[8] = E(0, 0, 3'b000, 2'b01, 2'b01, 0, 0);
        x[9] = 11'd0;
        x[10] = 11'd0;
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            issue(s[i], x[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_chk++;
            if (w_obs !== e) begin n_err++; $display("FAIL mem_stall[%0d]: got %b want %b", i, w_obs, e); end
            if (i >= 1 && i <= 5) begin
                n_chk++;
                if ({s_stall_if, s_bubble_ex, s_ifid, s_idex, s_exmem} !== 5'b10000) begin
                    n_err++; $display("FAIL mem_stall sat[%0d]: got %b want 10000", i,
                                      {s_stall_if, s_bubble_ex, s_ifid, s_idex, s_exmem});
                end
            end
            if (i == 6) begin
                n_chk++;
                if ({miss_cnt, stall_cnt, flush_cnt} !== {16'd5, 16'd2, 16'd1}) begin
                    n_err++; $display("FAIL mem_stall hold counters: got miss %0d stall %0d flush %0d want 5 2 1",
                                      miss_cnt, stall_cnt, flush_cnt);
                end
            end
        end
        n_chk++;
        if ({miss_cnt, stall_cnt, flush_cnt} !== {16'd5, 16'd3, 16'd1}) begin
            n_err++; $display("FAIL mem_stall counters: got miss %0d stall %0d flush %0d want 5 3 1",
                              miss_cnt, stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_saturation();
        stim_t s;
        exp_t  e;
        for (int i = 0; i < 21; i++) begin
            s = I(0, 0, 0, 0, 0, 0, 0, 0);
            s.ms = (i < 20);
            @(posedge clk); #1;
            issue(s, (i < 20) ? E(1, 0, 3'b000, 2'b00, 2'b00, 0, 0) : 11'd0);
            @(negedge clk);
            e = exp_q.pop_front();
            n_chk++;
            if (w_obs !== e) begin n_err++; $display("FAIL saturation[%0d]: got %b want %b", i, w_obs, e); end
        end
        n_chk++;
        if (s_miss_cnt !== 4'd15) begin n_err++; $display("FAIL saturation sat miss_cnt: got %0d want 15", s_miss_cnt); end
        n_chk++;
        if (miss_cnt !== 16'd25) begin n_err++; $display("FAIL saturation miss_cnt: got %0d want 25", miss_cnt); end
    endtask

    task automatic test_reset_mid();
        stim_t s[4];
        exp_t  x[4];
        exp_t  e;
        s = '{I(1, 3, 2, 1, 0, 1, 1, 2), I(1, 2, 2, 1, 1, 1, 0, 4), I(1, 2, 2, 1, 1, 1, 0, 4),
              I(0, 0, 0, 0, 0, 0, 0, 0)};
        s[1].rst_n = 1'b0; s[1].bt = 1'b1;
        x = '{11'd0, RST, 11'd0, 11'd0};
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            issue(s[i], x[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_chk++;
            if (w_obs !== e) begin n_err++; $display("FAIL reset_mid[%0d]: got %b want %b", i, w_obs, e); end
        end
        n_chk++;
        if ({stall_cnt, flush_cnt, miss_cnt} !== 48'd0) begin
            n_err++; $display("FAIL reset_mid counters: got %0d/%0d/%0d want 0/0/0", stall_cnt, flush_cnt, miss_cnt);
        end
        n_chk++;
        if (s_miss_cnt !== 4'd0) begin n_err++; $display("FAIL reset_mid sat miss_cnt: got %0d want 0", s_miss_cnt); end
    endtask

    initial begin
        rst_n = 1'b0; ms = 1'b0; bt = 1'b0; v = 1'b0;
        rs = '0; rt = '0; urs = 1'b0; urt = 1'b0; rw = 1'b0; mr = 1'b0; dst = '0;
        test_reset();
        test_forward();
        test_load_use();
        test_zero_reg();
        test_branch();
        test_mem_stall();
        test_saturation();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
